// File: rtl/serial_adder_if.sv
// Valid/ready operand and result channels of the digit-serial add/subtract unit.
// The producer/consumer side uses master; the adder itself uses slave.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: DIGIT bits per cycle, LSB digit first, registered carry,
// valid/ready on both sides. Result after WIDTH/DIGIT RUN cycles, held in DONE.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ov_q, ov_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DIGIT:0]       digit_sum;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic                 last_digit;
  logic                 msb_carry_in;

  // One digit of the full-adder datapath plus the values derived from it.
  always_comb begin
    digit_sum    = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
    sum_cat      = {digit_sum[DIGIT-1:0], sum_q};
    last_digit   = (cnt_q == CNT_W'(N - 1));
    // sum bit = a ^ b ^ carry_in, so the carry into the top bit falls out directly.
    msb_carry_in = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ digit_sum[DIGIT-1];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ov_d    = ov_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = sum_cat[WIDTH+DIGIT-1:DIGIT];
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_digit) begin
          cout_d  = digit_sum[DIGIT];
          ov_d    = msb_carry_in ^ digit_sum[DIGIT];
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand shift registers are pure data and are always reloaded on accept.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ov_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: DIGIT = 1, 4 and 16 instances fed the same operations,
// each checked against an arithmetic model every cycle its result is valid.
module tb_serial_adder;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // {overflow, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] xa, input logic [15:0] xb,
                                        input logic xcin, input logic xsub);
    int          uns;
    int          sgn;
    logic [15:0] bb;
    logic        c;
    bb  = xsub ? ~xb : xb;
    c   = xsub ? 1'b1 : xcin;
    uns = int'(xa) + int'(bb) + int'(c);
    if (xsub) sgn = int'($signed(xa)) - int'($signed(xb));
    else      sgn = int'($signed(xa)) + int'($signed(xb)) + int'(xcin);
    model = {(sgn < -32768 || sgn > 32767), (uns >= 65536), uns[15:0]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    localparam int N = W / D;

    serial_adder_if #(.WIDTH(W)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.cin       = cin;
    assign bus.sub       = sub;
    assign bus.out_ready = out_ready;

    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    logic [17:0] exp_q[$];
    int          acc_cyc = 0;
    bit          seen    = 1'b0;

    always @(posedge clk) begin
      if (rst) begin
        exp_q.delete();
        seen <= 1'b0;
      end else begin
        if (bus.out_valid && out_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          seen <= 1'b0;
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
          acc_cyc <= cyc;
        end
      end
    end

    always @(negedge clk) begin
      if (!rst && bus.out_valid) begin
        check($sformatf("d%0d_in_ready_in_done", D), 32'(bus.in_ready), 32'd0);
        check($sformatf("d%0d_inflight", D), 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          check($sformatf("d%0d_sum", D), 32'(bus.sum), 32'(exp_q[0][15:0]));
          check($sformatf("d%0d_cout", D), 32'(bus.cout), 32'(exp_q[0][16]));
          check($sformatf("d%0d_overflow", D), 32'(bus.overflow), 32'(exp_q[0][17]));
          if (!seen) begin
            check($sformatf("d%0d_latency", D), 32'(cyc - acc_cyc - 1), 32'(N));
            seen <= 1'b1;
          end
        end
      end
    end
  end

  function automatic bit all_ready();
    return g_dut[0].bus.in_ready && g_dut[1].bus.in_ready && g_dut[2].bus.in_ready;
  endfunction

  function automatic bit all_valid();
    return g_dut[0].bus.out_valid && g_dut[1].bus.out_valid && g_dut[2].bus.out_valid;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"}, 32'({g_dut[0].bus.in_ready, g_dut[1].bus.in_ready,
                                   g_dut[2].bus.in_ready}), 32'h7);
    check({tag, "_out_valid"}, 32'({g_dut[0].bus.out_valid, g_dut[1].bus.out_valid,
                                    g_dut[2].bus.out_valid}), 32'h0);
    check({tag, "_sum"}, 32'(g_dut[0].bus.sum | g_dut[1].bus.sum | g_dut[2].bus.sum), 32'h0);
    check({tag, "_cout_ov"}, 32'({g_dut[0].bus.cout, g_dut[1].bus.cout, g_dut[2].bus.cout,
                                  g_dut[0].bus.overflow, g_dut[1].bus.overflow,
                                  g_dut[2].bus.overflow}), 32'h0);
  endtask

  task automatic start_op(input logic [15:0] xa, input logic [15:0] xb,
                          input logic xcin, input logic xsub);
    int k;
    k = 0;
    while (!all_ready() && k < 50) begin
      tick();
      k++;
    end
    if (!all_ready()) check("wait_in_ready_timeout", 32'd0, 32'd1);
    a         = xa;
    b         = xb;
    cin       = xcin;
    sub       = xsub;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = ~xa;
    b        = 16'($urandom);
    cin      = ~xcin;
    sub      = ~xsub;
  endtask

  task automatic wait_valid(output int lat);
    int k;
    lat = 0;
    while (!g_dut[1].bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    k = 0;
    while (!all_valid() && k < 40) begin
      tick();
      k++;
    end
    if (!all_valid()) check("wait_out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_op();
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_to_idle", 32'(all_ready()), 32'd1);
  endtask

  task automatic directed(input string name, input logic [15:0] xa, input logic [15:0] xb,
                          input logic xcin, input logic xsub, input logic [15:0] esum,
                          input logic ecout, input logic eov);
    int lat;
    start_op(xa, xb, xcin, xsub);
    wait_valid(lat);
    @(negedge clk);
    check({name, "_sum"}, 32'(g_dut[1].bus.sum), 32'(esum));
    check({name, "_cout"}, 32'(g_dut[1].bus.cout), 32'(ecout));
    check({name, "_ov"}, 32'(g_dut[1].bus.overflow), 32'(eov));
    check({name, "_lat"}, 32'(lat), 32'd4);
    release_op();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;

    check("model_add", 32'(model(16'h1234, 16'h4321, 1'b0, 1'b0)), 32'h05555);
    check("model_wrap", 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'h10000);
    check("model_ovf", 32'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'h28000);
    check("model_sub", 32'(model(16'h0005, 16'h0007, 1'b1, 1'b1)), 32'h0FFFE);
    check("model_subov", 32'(model(16'h8000, 16'h0001, 1'b1, 1'b1)), 32'h37FFF);

    repeat (2) tick();
    @(negedge clk);
    check_idle_zero("reset");
    tick();
    rst = 1'b0;

    directed("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("subov", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("addcin", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Backpressure: result must hold while stray in_valid pulses are ignored.
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a        = 16'($urandom);
      b        = 16'($urandom);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp_out_valid", 32'(g_dut[1].bus.out_valid), 32'd1);
      check("bp_sum", 32'(g_dut[1].bus.sum), 32'h5555);
      check("bp_in_ready", 32'({g_dut[0].bus.in_ready, g_dut[1].bus.in_ready,
                                g_dut[2].bus.in_ready}), 32'h0);
    end
    release_op();

    // Reset after two digits of the DIGIT=4 unit.
    start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("midrun_reset");
    directed("after_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      start_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      wait_valid(lat);
      release_op();
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
